// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap sequencer:
// CSR addresses, trap kind encodings, cause codes and sequencer states.
package trap_pkg;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;

  localparam int unsigned CAUSE_ECALL  = 11;
  localparam int unsigned CAUSE_EBREAK = 3;

  // Bit positions inside mstatus touched on trap entry/return.
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  typedef enum logic [1:0] {
    KIND_ECALL  = 2'b00,
    KIND_EBREAK = 2'b01,
    KIND_MRET   = 2'b10,
    KIND_RSVD   = 2'b11
  } trap_kind_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_R_MST,
    ST_W_MST,
    ST_R_TVEC,
    ST_R_EPC,
    ST_REDIRECT,
    ST_DROP
  } state_e;

endpackage

// File: rtl/trap_seq.sv
// Machine-mode trap sequencer: drives CSR traffic for ecall/ebreak/mret and redirects the PC.
// Optional mstatus MIE/MPIE handling is compiled in when TRAP_MSTATUS_EN is defined.
module trap_seq
  import trap_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              trap_valid,
  output logic              trap_ready,
  input  logic [1:0]        trap_kind,
  input  logic [XLEN-1:0]   trap_pc,
  output logic              stall,
  output logic              csr_req,
  output logic              csr_we,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic              csr_ack,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  // PCs and vector bases are word aligned: clear the two low bits.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_e          state_q, state_d;
  trap_kind_e      kind_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] target_q;
`ifdef TRAP_MSTATUS_EN
  logic [XLEN-1:0] mst_q;
`endif

  assign trap_ready = (state_q == ST_IDLE);
  assign stall      = (state_q != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      kind_q   <= KIND_ECALL;
      pc_q     <= '0;
      target_q <= '0;
`ifdef TRAP_MSTATUS_EN
      mst_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (trap_valid && trap_ready) begin
        kind_q <= trap_kind_e'(trap_kind);
        pc_q   <= trap_pc;
      end
      if (csr_ack && ((state_q == ST_R_TVEC) || (state_q == ST_R_EPC))) begin
        target_q <= csr_rdata & ALIGN_MASK;
      end
`ifdef TRAP_MSTATUS_EN
      if (csr_ack && (state_q == ST_R_MST)) begin
        mst_q <= csr_rdata;
      end
`endif
    end
  end

  // NOTE: every output and the next state get a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    csr_req        = 1'b0;
    csr_we         = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (trap_valid) begin
          unique case (trap_kind_e'(trap_kind))
            KIND_ECALL, KIND_EBREAK: state_d = ST_W_EPC;
            KIND_MRET:               state_d = ST_R_EPC;
            default:                 state_d = ST_DROP;
          endcase
        end
      end

      ST_W_EPC: begin
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_AW'(MEPC);
        csr_wdata = pc_q & ALIGN_MASK;
        if (csr_ack) state_d = ST_W_CAUSE;
      end

      ST_W_CAUSE: begin
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_AW'(MCAUSE);
        csr_wdata = (kind_q == KIND_EBREAK) ? XLEN'(CAUSE_EBREAK) : XLEN'(CAUSE_ECALL);
`ifdef TRAP_MSTATUS_EN
        if (csr_ack) state_d = ST_R_MST;
`else
        if (csr_ack) state_d = ST_R_TVEC;
`endif
      end

`ifdef TRAP_MSTATUS_EN
      ST_R_MST: begin
        csr_req  = 1'b1;
        csr_addr = CSR_AW'(MSTATUS);
        if (csr_ack) state_d = ST_W_MST;
      end

      ST_W_MST: begin
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_AW'(MSTATUS);
        csr_wdata = mst_q;
        if (kind_q == KIND_MRET) begin
          csr_wdata[MSTATUS_MIE]  = mst_q[MSTATUS_MPIE];
          csr_wdata[MSTATUS_MPIE] = 1'b1;
        end else begin
          csr_wdata[MSTATUS_MPIE] = mst_q[MSTATUS_MIE];
          csr_wdata[MSTATUS_MIE]  = 1'b0;
        end
        if (csr_ack) state_d = (kind_q == KIND_MRET) ? ST_REDIRECT : ST_R_TVEC;
      end
`endif

      ST_R_TVEC: begin
        csr_req  = 1'b1;
        csr_addr = CSR_AW'(MTVEC);
        if (csr_ack) state_d = ST_REDIRECT;
      end

      ST_R_EPC: begin
        csr_req  = 1'b1;
        csr_addr = CSR_AW'(MEPC);
`ifdef TRAP_MSTATUS_EN
        if (csr_ack) state_d = ST_R_MST;
`else
        if (csr_ack) state_d = ST_REDIRECT;
`endif
      end

      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = ST_IDLE;
      end

      ST_DROP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Self-checking bench for trap_seq: a CSR-file responder with random ack delays and
// a transaction-level model (expected access list + redirect target) checked every cycle.
`timescale 1ns/1ps
module tb_trap_seq;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_NONE    = 12'hfff;
`ifdef TRAP_MSTATUS_EN
  localparam int ENTRY_ACC = 5;
  localparam int MRET_ACC  = 3;
`else
  localparam int ENTRY_ACC = 3;
  localparam int MRET_ACC  = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trap_valid = 1'b0;
  logic [1:0]  trap_kind = 2'b00;
  logic [31:0] trap_pc = 32'h0;
  logic        csr_ack = 1'b0;
  logic [31:0] csr_rdata = 32'h0;
  logic        trap_ready, stall, csr_req, csr_we, redirect_valid;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, redirect_pc;

  always #5 clk = ~clk;

  trap_seq #(.XLEN(32), .CSR_AW(12)) dut (
    .clk(clk), .rstn(rstn),
    .trap_valid(trap_valid), .trap_ready(trap_ready),
    .trap_kind(trap_kind), .trap_pc(trap_pc), .stall(stall),
    .csr_req(csr_req), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_ack(csr_ack), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench-side CSR file and transaction-level model.
  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } acc_t;
  typedef enum {M_IDLE, M_ACC, M_RED, M_DROP} phase_e;

  logic [31:0] csr_file [0:4095];
  acc_t        exp_q[$];
  phase_e      phase = M_IDLE;
  logic [31:0] exp_target = 32'h0;

  int          cyc = 0, acc_cycle = 0, red_cycle = 0;
  int          n_redirects = 0, n_req_cycles = 0, n_stall_cycles = 0;
  logic [31:0] red_pc = 32'h0;
  int          dly_lo = 0, dly_hi = 0, ack_wait = 0;
  logic [11:0] hold_addr = A_NONE;
  bit          spurious = 1'b0;
  logic        prev_req = 1'b0, prev_we = 1'b0;
  logic [11:0] prev_addr = 12'h0;
  logic [31:0] prev_wdata = 32'h0;

  // Expected CSR traffic and redirect target for one accepted trap.
  function automatic void build(input logic [1:0] k, input logic [31:0] pc);
`ifdef TRAP_MSTATUS_EN
    logic [31:0] m;
    m = csr_file[A_MSTATUS];
`endif
    exp_q.delete();
    case (k)
      2'b00, 2'b01: begin
        exp_q.push_back('{1'b1, A_MEPC, pc & 32'hFFFF_FFFC});
        exp_q.push_back('{1'b1, A_MCAUSE, (k == 2'b00) ? 32'd11 : 32'd3});
`ifdef TRAP_MSTATUS_EN
        exp_q.push_back('{1'b0, A_MSTATUS, 32'h0});
        exp_q.push_back('{1'b1, A_MSTATUS, (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0)});
`endif
        exp_q.push_back('{1'b0, A_MTVEC, 32'h0});
        exp_target = csr_file[A_MTVEC] & 32'hFFFF_FFFC;
      end
      2'b10: begin
        exp_q.push_back('{1'b0, A_MEPC, 32'h0});
`ifdef TRAP_MSTATUS_EN
        exp_q.push_back('{1'b0, A_MSTATUS, 32'h0});
        exp_q.push_back('{1'b1, A_MSTATUS, (m & ~32'h88) | 32'h80 | (m[7] ? 32'h8 : 32'h0)});
`endif
        exp_target = csr_file[A_MEPC] & 32'hFFFF_FFFC;
      end
      default: ;
    endcase
  endfunction

  // Compare process: advance the model over the edge just passed, check outputs, drive ack.
  always @(negedge clk) begin
    bit new_head;
    new_head = 1'b0;
    cyc++;
    if (!rstn) begin
      phase = M_IDLE;
      exp_q.delete();
      csr_ack = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (prev_req && csr_ack && prev_we) csr_file[prev_addr] = prev_wdata;
      case (phase)
        M_IDLE: if (trap_valid) begin
          build(trap_kind, trap_pc);
          acc_cycle = cyc - 1;
          phase = (exp_q.size() != 0) ? M_ACC : M_DROP;
          new_head = 1'b1;
        end
        M_ACC: if (csr_ack) begin
          exp_q.delete(0);
          if (exp_q.size() == 0) phase = M_RED;
          new_head = 1'b1;
        end
        default: phase = M_IDLE;
      endcase

      check("trap_ready", 32'(trap_ready), 32'(phase == M_IDLE));
      check("stall", 32'(stall), 32'(phase != M_IDLE));
      check("csr_req", 32'(csr_req), 32'(phase == M_ACC));
      if (phase == M_ACC) begin
        check("csr_addr", 32'(csr_addr), 32'(exp_q[0].addr));
        check("csr_we", 32'(csr_we), 32'(exp_q[0].we));
        if (exp_q[0].we) check("csr_wdata", csr_wdata, exp_q[0].wdata);
      end
      check("redirect_valid", 32'(redirect_valid), 32'(phase == M_RED));
      if (phase == M_RED) check("redirect_pc", redirect_pc, exp_target);

      if (redirect_valid) begin
        n_redirects++;
        red_cycle = cyc;
        red_pc = redirect_pc;
      end
      if (csr_req) n_req_cycles++;
      if (stall) n_stall_cycles++;
      prev_req = csr_req;
      prev_we = csr_we;
      prev_addr = csr_addr;
      prev_wdata = csr_wdata;

      if (phase == M_ACC) begin
        if (new_head) ack_wait = int'($urandom_range(dly_hi, dly_lo));
        if (csr_addr == hold_addr) begin
          csr_ack = 1'b0;
        end else if (ack_wait == 0) begin
          csr_ack = 1'b1;
          csr_rdata = csr_file[csr_addr];
        end else begin
          csr_ack = 1'b0;
          ack_wait--;
        end
      end else begin
        csr_ack = spurious && ($urandom_range(0, 3) == 0);
        csr_rdata = $urandom;
      end
    end
  end

  // Present a trap and hold it until the edge that accepts it.
  task automatic do_trap(input logic [1:0] k, input logic [31:0] pc);
    int n;
    @(negedge clk); #1;
    trap_valid = 1'b1;
    trap_kind = k;
    trap_pc = pc;
    n = 0;
    while (!trap_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept_timeout", 32'(trap_ready), 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_idle();
    int n;
    @(negedge clk); #1;
    trap_valid = 1'b0;
    n = 0;
    while (!trap_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(trap_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s_stall, s_req, s_red, n;
    for (int i = 0; i < 4096; i++) csr_file[i] = 32'h0;

    // Reset values.
    @(negedge clk); #1;
    check("rst_trap_ready", 32'(trap_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_csr_req", 32'(csr_req), 32'd0);
    check("rst_csr_we", 32'(csr_we), 32'd0);
    check("rst_csr_addr", 32'(csr_addr), 32'd0);
    check("rst_csr_wdata", csr_wdata, 32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk); #3;
    rstn = 1'b1;

    // Ecall, zero-wait ack.
    csr_file[A_MTVEC] = 32'h8000_0201;
    s_stall = n_stall_cycles;
    s_red = n_redirects;
    do_trap(2'b00, 32'h8000_0104);
    wait_idle();
    check("ecall_mepc", csr_file[A_MEPC], 32'h8000_0104);
    check("ecall_mcause", csr_file[A_MCAUSE], 32'd11);
    check("ecall_target", red_pc, 32'h8000_0200);
    check("ecall_latency", 32'(red_cycle - acc_cycle), 32'(ENTRY_ACC + 1));
    check("ecall_stall_cycles", 32'(n_stall_cycles - s_stall), 32'(ENTRY_ACC + 1));
    check("ecall_redirects", 32'(n_redirects - s_red), 32'd1);

    // Mret, every ack delayed 3 cycles.
    csr_file[A_MEPC] = 32'h8000_010A;
    dly_lo = 3; dly_hi = 3;
    s_req = n_req_cycles;
    s_stall = n_stall_cycles;
    do_trap(2'b10, 32'h0000_1234);
    wait_idle();
    check("mret_target", red_pc, 32'h8000_0108);
    check("mret_req_cycles", 32'(n_req_cycles - s_req), 32'(4 * MRET_ACC));
    check("mret_stall_cycles", 32'(n_stall_cycles - s_stall), 32'(4 * MRET_ACC + 1));

    // Ebreak with random delays, next request held high while busy.
    dly_lo = 0; dly_hi = 5;
    do_trap(2'b01, 32'h8000_3007);
    do_trap(2'b11, 32'h0000_0000);
    wait_idle();
    check("ebreak_mcause", csr_file[A_MCAUSE], 32'd3);
    check("ebreak_mepc", csr_file[A_MEPC], 32'h8000_3004);

    // Reserved kind: one stall cycle, no CSR traffic, no redirect.
    s_stall = n_stall_cycles;
    s_req = n_req_cycles;
    s_red = n_redirects;
    do_trap(2'b11, 32'h0000_0040);
    wait_idle();
    check("drop_stall_cycles", 32'(n_stall_cycles - s_stall), 32'd1);
    check("drop_req_cycles", 32'(n_req_cycles - s_req), 32'd0);
    check("drop_redirects", 32'(n_redirects - s_red), 32'd0);

    // Reset while the mcause write waits for its ack.
    dly_lo = 0; dly_hi = 0;
    hold_addr = A_MCAUSE;
    s_red = n_redirects;
    do_trap(2'b00, 32'h8000_0400);
    @(negedge clk); #1;
    trap_valid = 1'b0;
    n = 0;
    while (!(csr_req && csr_addr == A_MCAUSE) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("reach_w_cause", 32'(csr_req && csr_addr == A_MCAUSE), 32'd1);
    @(negedge clk); #3;
    rstn = 1'b0;
    #1;
    check("midrst_csr_req", 32'(csr_req), 32'd0);
    check("midrst_csr_addr", 32'(csr_addr), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_trap_ready", 32'(trap_ready), 32'd1);
    check("midrst_redirect_valid", 32'(redirect_valid), 32'd0);
    repeat (2) @(negedge clk);
    #3;
    rstn = 1'b1;
    hold_addr = A_NONE;
    repeat (3) @(negedge clk);
    check("midrst_no_redirect", 32'(n_redirects - s_red), 32'd0);
    check("midrst_mcause_kept", csr_file[A_MCAUSE], 32'd3);
    csr_file[A_MTVEC] = 32'h0000_1004;
    do_trap(2'b00, 32'h0000_2003);
    wait_idle();
    check("postrst_target", red_pc, 32'h0000_1004);
    check("postrst_mepc", csr_file[A_MEPC], 32'h0000_2000);
    check("postrst_mcause", csr_file[A_MCAUSE], 32'd11);

`ifdef TRAP_MSTATUS_EN
    // mstatus MIE/MPIE shuffling on entry and return.
    csr_file[A_MSTATUS] = 32'h8;
    do_trap(2'b00, 32'h8000_0500);
    wait_idle();
    check("mst_entry", csr_file[A_MSTATUS], 32'h80);
    do_trap(2'b10, 32'h0);
    wait_idle();
    check("mst_mret", csr_file[A_MSTATUS], 32'h88);
`else
    check("mst_untouched", csr_file[A_MSTATUS], 32'h0);
`endif

    // Random back-to-back traffic with random delays and stray acks.
    spurious = 1'b1;
    dly_lo = 0; dly_hi = 5;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_idle();
        csr_file[A_MTVEC] = $urandom;
      end
      do_trap(2'($urandom_range(0, 3)), $urandom);
    end
    wait_idle();
    spurious = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
